// File: rtl/reg_pkg.sv
// reg_pkg: shared defaults, named register indices and the byte-lane merge helper.
package reg_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    localparam int LOOP_REG  = 0;
    localparam int STEP_REG  = 1;
    localparam int PU_REG    = 13;
    localparam int SP_REG    = 14;
    localparam int PC_REG    = 15;

    localparam int LOOP_INIT = 10;

    // Widest register the merge helper handles; callers zero-extend into it.
    localparam int MAX_WIDTH = 256;
    localparam int MAX_LANES = MAX_WIDTH / 8;

    function automatic logic [MAX_WIDTH-1:0] byte_merge(
        input logic [MAX_WIDTH-1:0] old_v,
        input logic [MAX_WIDTH-1:0] new_v,
        input logic [MAX_LANES-1:0] be
    );
        logic [MAX_WIDTH-1:0] r;
        r = old_v;
        for (int i = 0; i < MAX_LANES; i++)
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// reg_read_port: registered read port selecting from the next-state register array.
module reg_read_port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] next_regs [DEPTH],
    output logic [WIDTH-1:0] rdata
);
    import reg_pkg::*;

    logic [WIDTH-1:0] rdata_d, rdata_q;

    // Address decode doubles as the range check: unmatched addresses read as zero.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < DEPTH; i++)
            rdata_d = (addr == AW'(i)) ? next_regs[i] : rdata_d;
    end

    // Output register, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with byte-lane writes, loop counter and auto-increment PC.
module reg_file_param #(
    parameter int WIDTH     = reg_pkg::DEF_WIDTH,
    parameter int DEPTH     = reg_pkg::DEF_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter int LOOP_REG  = reg_pkg::LOOP_REG,
    parameter int LOOP_INIT = reg_pkg::LOOP_INIT,
    parameter int PC_REG    = DEPTH - 1,
    parameter int PC_STEP   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      A1,
    input  logic [AW-1:0]      A2,
    input  logic [AW-1:0]      A3,
    input  logic               regWrite,
    input  logic [WIDTH/8-1:0] BE3,
    input  logic [WIDTH-1:0]   WD3,
    input  logic               loopDec,
    input  logic               pcInc,
    output logic [WIDTH-1:0]   RD1,
    output logic [WIDTH-1:0]   RD2,
    output logic [WIDTH-1:0]   pcOut,
    output logic               loopZero,
    output logic               loopDone
);
    import reg_pkg::*;

    localparam logic [WIDTH-1:0] LOOP_RST = WIDTH'(LOOP_INIT);
    localparam logic [WIDTH-1:0] PC_INC   = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    if (WIDTH % 8 != 0 || WIDTH < 8 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("reg_file_param: WIDTH must be a multiple of 8 between 8 and %0d", MAX_WIDTH);
    end
    if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
        $error("reg_file_param: DEPTH must be within 2..256");
    end
    if (AW != $clog2(DEPTH)) begin : g_bad_aw
        $error("reg_file_param: AW is derived from DEPTH and must not be overridden");
    end
    if (LOOP_REG < 0 || LOOP_REG >= DEPTH || PC_REG < 0 || PC_REG >= DEPTH) begin : g_bad_index
        $error("reg_file_param: LOOP_REG and PC_REG must index existing registers");
    end
    if (LOOP_REG == PC_REG) begin : g_shared_index
        $warning("reg_file_param: LOOP_REG equals PC_REG; loop counter behaviour takes precedence");
    end

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             loop_done_d, loop_done_q;
    logic             wr_any;

    // A write with no lanes enabled is treated as no write at all, so it does not mask loop/PC updates.
    assign wr_any = regWrite && (BE3 != '0);

    // Next state per register: write beats loop decrement beats PC increment beats hold.
    always_comb begin
        loop_done_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_any && A3 == AW'(i))
                regs_d[i] = WIDTH'(byte_merge(MAX_WIDTH'(regs_q[i]), MAX_WIDTH'(WD3), MAX_LANES'(BE3)));
            else if (i == LOOP_REG && loopDec) begin
                regs_d[i]   = (regs_q[i] == '0) ? regs_q[i] : regs_q[i] - ONE;
                loop_done_d = (regs_q[i] == ONE);
            end
            else if (i == PC_REG && pcInc)
                regs_d[i] = regs_q[i] + PC_INC;
        end
    end

    // Register array and done pulse; only the loop counter has a non-zero reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= (i == LOOP_REG) ? LOOP_RST : '0;
            loop_done_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= regs_d[i];
            loop_done_q <= loop_done_d;
        end
    end

    assign pcOut    = regs_q[PC_REG];
    assign loopZero = (regs_q[LOOP_REG] == '0);
    assign loopDone = loop_done_q;

    reg_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd1 (
        .clk       (clk),
        .rst       (rst),
        .addr      (A1),
        .next_regs (regs_d),
        .rdata     (RD1)
    );

    reg_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd2 (
        .clk       (clk),
        .rst       (rst),
        .addr      (A2),
        .next_regs (regs_d),
        .rdata     (RD2)
    );

endmodule
